branch_update_queue: RTL

In-order FIFO of in-flight branch predictions, placed between fetch (where branch_history_table is read) and the execute-stage branch resolver. Fetch pushes the index, tag and predicted direction of every predicted branch. Execute resolves branches oldest-first; this block then drives the table's write port one cycle later with the saved index/tag and the actual outcome. It also flags mispredictions and discards the wrong-path entries that follow.

---
 rtl/branch_update_queue.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/branch_update_queue.sv
// branch_update_queue
// In-order FIFO of in-flight branch predictions. It sits between fetch, where
// the branch history table is read, and the execute-stage branch resolver.
// Fetch pushes {index, tag, predicted direction} for each predicted branch.
// Execute resolves branches oldest-first. One cycle after a resolve, this
// block drives the table write port with the saved index/tag and the actual
// outcome. A mispredicting resolve discards all younger (wrong-path) entries.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   push_valid_i/_index_i/_tag_i/_pred_taken_i, push_ready_o
//                                  fetch-side push interface
//   resolve_valid_i, resolve_taken_i
//                                  resolution of the oldest branch
//   bht_write_enabled_o, bht_index_write_o, bht_tag_bits_write_o,
//   bht_increment_decrement_o      table write port (registered)
//   mispredict_o                   pulse aligned with the write strobe
//   empty_o, occupancy_o           queue status
//   mispredict_count_o             saturating count of mispredicts; this port
//                                  exists only when BRANCH_UPDATE_QUEUE_STATS_EN
//                                  is defined
//
// FSM states:
//   state     | meaning
//   S_RUN     | normal operation, pushes and resolves accepted
//   S_RECOVER | one cycle after a flush; pushes blocked, resolves ignored
module branch_update_queue #(
  parameter int INDEX_LEN = 7,
  parameter int TAG_LEN   = 7,
  parameter int DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_valid_i,
  input  logic [INDEX_LEN-1:0]       push_index_i,
  input  logic [TAG_LEN-1:0]         push_tag_i,
  input  logic                       push_pred_taken_i,
  output logic                       push_ready_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  output logic                       bht_write_enabled_o,
  output logic [INDEX_LEN-1:0]       bht_index_write_o,
  output logic [TAG_LEN-1:0]         bht_tag_bits_write_o,
  output logic                       bht_increment_decrement_o,
  output logic                       mispredict_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  ,
  output logic [15:0]                mispredict_count_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_RECOVER = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [INDEX_LEN-1:0] idx_mem_q [DEPTH];
  logic [TAG_LEN-1:0]   tag_mem_q [DEPTH];
  logic [DEPTH-1:0]     pred_mem_q;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic do_pop;
  logic do_push;
  logic mis_now;

  assign empty_o     = (count_q == '0);
  assign occupancy_o = count_q;

  // Resolves are only honoured in RUN; in RECOVER the queue is empty anyway.
  assign do_pop  = resolve_valid_i && !empty_o && (state_q == S_RUN);
  assign mis_now = do_pop && (resolve_taken_i != pred_mem_q[head_q]);
  // A push alongside a mispredict is wrong-path and gets dropped.
  assign do_push = push_valid_i && push_ready_o && !mis_now;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     if (mis_now) state_d = S_RECOVER;
      S_RECOVER: state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    push_ready_o = (state_q == S_RUN) && (count_q < CNT_W'(DEPTH));
  end

  // Pointer and occupancy update
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mis_now) begin
      // Flush everything younger than the popped head.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
      pred_mem_q <= '0;
    end else if (do_push) begin
      idx_mem_q[tail_q]  <= push_index_i;
      tag_mem_q[tail_q]  <= push_tag_i;
      pred_mem_q[tail_q] <= push_pred_taken_i;
    end
  end

  // Table write stage: data fields hold between writes, strobes are pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bht_write_enabled_o       <= 1'b0;
      mispredict_o              <= 1'b0;
      bht_index_write_o         <= '0;
      bht_tag_bits_write_o      <= '0;
      bht_increment_decrement_o <= 1'b0;
    end else begin
      bht_write_enabled_o <= do_pop;
      mispredict_o        <= mis_now;
      if (do_pop) begin
        bht_index_write_o         <= idx_mem_q[head_q];
        bht_tag_bits_write_o      <= tag_mem_q[head_q];
        bht_increment_decrement_o <= resolve_taken_i;
      end
    end
  end

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
  logic [15:0] mis_cnt_q;

  // Counts the registered pulse so the count tracks mispredict_o exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 mis_cnt_q <= '0;
    else if (mispredict_o && mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
  end

  assign mispredict_count_o = mis_cnt_q;
`endif

endmodule
